// File: rtl/ex_wb_pkg.sv
// Shared types and constants for the execute-to-writeback stage:
// instruction kinds, ALU opcodes, overflow status codes and the queue entry.
package ex_wb_pkg;

    typedef enum logic [1:0] {
        KIND_R     = 2'b00,
        KIND_ADDI  = 2'b01,
        KIND_OTHER = 2'b10,
        KIND_RSVD  = 2'b11
    } instr_kind_e;

    localparam logic [4:0] ALU_ADD = 5'd0;
    localparam logic [4:0] ALU_SUB = 5'd1;

    localparam logic [1:0] RSTATUS_NONE     = 2'd0;
    localparam logic [1:0] RSTATUS_ADD_OVF  = 2'd1;
    localparam logic [1:0] RSTATUS_ADDI_OVF = 2'd2;
    localparam logic [1:0] RSTATUS_SUB_OVF  = 2'd3;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } wb_entry_t;

    // RSTATUS_NONE means the overflow is not trapped for this kind/opcode.
    function automatic logic [1:0] trap_code(input instr_kind_e kind, input logic [4:0] opcode);
        trap_code = RSTATUS_NONE;
        case (kind)
            KIND_R: begin
                if (opcode == ALU_ADD)      trap_code = RSTATUS_ADD_OVF;
                else if (opcode == ALU_SUB) trap_code = RSTATUS_SUB_OVF;
            end
            KIND_ADDI: trap_code = RSTATUS_ADDI_OVF;
            default:   trap_code = RSTATUS_NONE;
        endcase
    endfunction

endpackage

// File: rtl/ex_wb_if.sv
// Execute-result input and register-file writeback handshake bundle.
// The slave modport is the stage side; the master modport drives it.
interface ex_wb_if;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] alu_result;
    logic        alu_overflow;
    logic [4:0]  alu_opcode;
    logic [1:0]  instr_kind;
    logic [4:0]  dest_reg;
    logic        wb_valid;
    logic        wb_ready;
    logic [4:0]  wb_reg;
    logic [31:0] wb_data;

    modport slave (
        input  in_valid, alu_result, alu_overflow, alu_opcode, instr_kind, dest_reg, wb_ready,
        output in_ready, wb_valid, wb_reg, wb_data
    );

    modport master (
        output in_valid, alu_result, alu_overflow, alu_opcode, instr_kind, dest_reg, wb_ready,
        input  in_ready, wb_valid, wb_reg, wb_data
    );
endinterface

// File: rtl/wb_skid_fifo.sv
// Two-entry in-order queue of writeback entries; head is presented directly.
// Not ready while reset is asserted so nothing is accepted during reset.
module wb_skid_fifo
    import ex_wb_pkg::*;
(
    input  logic      i_clk,
    input  logic      i_rst_n,
    input  logic      i_push,
    input  wb_entry_t i_data,
    output logic      o_ready,
    output logic      o_valid,
    input  logic      i_pop,
    output wb_entry_t o_data
);

    wb_entry_t  r_mem [2];
    logic       r_wr_ptr;
    logic       r_rd_ptr;
    logic [1:0] r_count;
    logic       w_push;
    logic       w_pop;

    assign o_ready = i_rst_n && (r_count != 2'd2);
    assign o_valid = (r_count != 2'd0);
    assign w_push  = i_push && o_ready;
    assign w_pop   = o_valid && i_pop;
    assign o_data  = r_mem[r_rd_ptr];

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mem[0] <= '0;
            r_mem[1] <= '0;
            r_wr_ptr <= 1'b0;
            r_rd_ptr <= 1'b0;
            r_count  <= 2'd0;
        end else begin
            if (w_push) begin
                r_mem[r_wr_ptr] <= i_data;
                r_wr_ptr        <= ~r_wr_ptr;
            end
            if (w_pop) begin
                r_rd_ptr <= ~r_rd_ptr;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + 2'd1;
                2'b01:   r_count <= r_count - 2'd1;
                default: r_count <= r_count;
            endcase
        end
    end

endmodule

// File: rtl/ex_wb_stage.sv
// Execute-to-writeback stage: maps ALU results (or overflow status codes) into
// a 2-entry writeback queue. Overflow trapping is enabled by EX_WB_OVF_TRAP_EN.
module ex_wb_stage
    import ex_wb_pkg::*;
#(
    parameter int unsigned RSTATUS_REG = 30,
    parameter int unsigned CNT_W       = 16
) (
    input  logic             clock,
    input  logic             ctrl_reset_n,
    ex_wb_if.slave           ex_wb,
    output logic [CNT_W-1:0] ovf_count
);

    logic       w_trap;
    logic [1:0] w_code;
    logic       w_fifo_ready;
    logic       w_accept;
    logic       w_enq;
    wb_entry_t  w_entry;
    wb_entry_t  w_head;

`ifdef EX_WB_OVF_TRAP_EN
    assign w_code = trap_code(instr_kind_e'(ex_wb.instr_kind), ex_wb.alu_opcode);
    assign w_trap = ex_wb.alu_overflow && (w_code != RSTATUS_NONE);
`else
    logic w_unused_trap_inputs;
    assign w_unused_trap_inputs = ^{ex_wb.alu_overflow, ex_wb.alu_opcode, ex_wb.instr_kind};
    assign w_code = RSTATUS_NONE;
    assign w_trap = 1'b0;
`endif

    always_comb begin
        w_entry.rd   = ex_wb.dest_reg;
        w_entry.data = ex_wb.alu_result;
        if (w_trap) begin
            w_entry.rd   = 5'(RSTATUS_REG);
            w_entry.data = {30'd0, w_code};
        end
    end

    // Writes to x0 complete the handshake but are dropped; traps always land.
    assign w_enq    = w_trap || (ex_wb.dest_reg != 5'd0);
    assign w_accept = ex_wb.in_valid && w_fifo_ready;

    wb_skid_fifo u_fifo (
        .i_clk   (clock),
        .i_rst_n (ctrl_reset_n),
        .i_push  (w_accept && w_enq),
        .i_data  (w_entry),
        .o_ready (w_fifo_ready),
        .o_valid (ex_wb.wb_valid),
        .i_pop   (ex_wb.wb_ready),
        .o_data  (w_head)
    );

    assign ex_wb.in_ready = w_fifo_ready;
    assign ex_wb.wb_reg   = w_head.rd;
    assign ex_wb.wb_data  = w_head.data;

`ifdef EX_WB_OVF_TRAP_EN
    logic [CNT_W-1:0] r_ovf_count;

    always_ff @(posedge clock or negedge ctrl_reset_n) begin
        if (!ctrl_reset_n) begin
            r_ovf_count <= '0;
        end else if (w_accept && w_trap && (r_ovf_count != '1)) begin
            r_ovf_count <= r_ovf_count + CNT_W'(1);
        end
    end

    assign ovf_count = r_ovf_count;
`else
    assign ovf_count = '0;
`endif

endmodule

// File: tb/tb_ex_wb_stage.sv
// Directed bench for ex_wb_stage: single-push vector table plus hand sequences
// for backpressure, mid-transfer reset and counter saturation (CNT_W=2).
module tb_ex_wb_stage;

`ifdef EX_WB_OVF_TRAP_EN
    localparam bit TRAP_ON = 1'b1;
`else
    localparam bit TRAP_ON = 1'b0;
`endif

    logic       clock;
    logic       ctrl_reset_n;
    logic [1:0] ovf_count;
    int         n_checks;
    int         n_fail;

    ex_wb_if u_if ();

    ex_wb_stage #(.RSTATUS_REG(30), .CNT_W(2)) dut (
        .clock        (clock),
        .ctrl_reset_n (ctrl_reset_n),
        .ex_wb        (u_if),
        .ovf_count    (ovf_count)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        logic [4:0]  dest;
        logic [31:0] res;
        logic        ovf;
        logic [4:0]  op;
        logic [1:0]  kind;
        logic        exp_v;
        logic [4:0]  exp_reg;
        logic [31:0] exp_data;
        int          exp_cnt;
    } vec_t;

    vec_t vecs [10];
    int   sat_exp [4];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    task automatic drive(input logic v, input logic [4:0] dest, input logic [31:0] res,
                         input logic ovf, input logic [4:0] op, input logic [1:0] kind);
        u_if.in_valid     = v;
        u_if.dest_reg     = dest;
        u_if.alu_result   = res;
        u_if.alu_overflow = ovf;
        u_if.alu_opcode   = op;
        u_if.instr_kind   = kind;
    endtask

    initial begin
        n_checks = 0;
        n_fail   = 0;

        //              dest   result          ovf   op     kind   exp_v  exp_reg                     exp_data                          cnt
        vecs[0] = '{5'd5,  32'h0000_1234, 1'b0, 5'd0, 2'b00, 1'b1, 5'd5,                       32'h0000_1234,                     0};
        vecs[1] = '{5'd7,  32'hDEAD_BEEF, 1'b1, 5'd1, 2'b00, 1'b1, TRAP_ON ? 5'd30 : 5'd7,     TRAP_ON ? 32'd3 : 32'hDEAD_BEEF,   TRAP_ON ? 1 : 0};
        vecs[2] = '{5'd9,  32'h0000_0011, 1'b1, 5'd0, 2'b01, 1'b1, TRAP_ON ? 5'd30 : 5'd9,     TRAP_ON ? 32'd2 : 32'h11,          TRAP_ON ? 2 : 0};
        vecs[3] = '{5'd3,  32'h0000_0022, 1'b1, 5'd0, 2'b00, 1'b1, TRAP_ON ? 5'd30 : 5'd3,     TRAP_ON ? 32'd1 : 32'h22,          TRAP_ON ? 3 : 0};
        vecs[4] = '{5'd4,  32'h0000_0033, 1'b1, 5'd0, 2'b10, 1'b1, 5'd4,                       32'h33,                            TRAP_ON ? 3 : 0};
        vecs[5] = '{5'd6,  32'h0000_0044, 1'b1, 5'd1, 2'b11, 1'b1, 5'd6,                       32'h44,                            TRAP_ON ? 3 : 0};
        vecs[6] = '{5'd8,  32'h0000_0055, 1'b1, 5'd2, 2'b00, 1'b1, 5'd8,                       32'h55,                            TRAP_ON ? 3 : 0};
        vecs[7] = '{5'd0,  32'h0000_0066, 1'b0, 5'd0, 2'b00, 1'b0, 5'd0,                       32'h0,                             TRAP_ON ? 3 : 0};
        vecs[8] = '{5'd0,  32'h0000_0077, 1'b1, 5'd0, 2'b01, TRAP_ON, 5'd30,                   32'd2,                             TRAP_ON ? 3 : 0};
        vecs[9] = '{5'd31, 32'hFFFF_FFFF, 1'b0, 5'd0, 2'b00, 1'b1, 5'd31,                      32'hFFFF_FFFF,                     TRAP_ON ? 3 : 0};

        sat_exp[0] = TRAP_ON ? 1 : 0;
        sat_exp[1] = TRAP_ON ? 2 : 0;
        sat_exp[2] = TRAP_ON ? 3 : 0;
        sat_exp[3] = TRAP_ON ? 3 : 0;

        // Reset state
        ctrl_reset_n  = 1'b0;
        u_if.wb_ready = 1'b1;
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00);
        #2;
        chk("rst_in_ready", u_if.in_ready, 0);
        chk("rst_wb_valid", u_if.wb_valid, 0);
        chk("rst_wb_reg",   u_if.wb_reg, 0);
        chk("rst_wb_data",  u_if.wb_data, 0);
        chk("rst_ovf_count", ovf_count, 0);
        tick();
        tick();
        ctrl_reset_n = 1'b1;
        #1;
        chk("post_rst_in_ready", u_if.in_ready, 1);

        // Single-push vectors into an empty queue with wb_ready high
        for (int i = 0; i < 10; i++) begin
            drive(1'b1, vecs[i].dest, vecs[i].res, vecs[i].ovf, vecs[i].op, vecs[i].kind);
            chk($sformatf("v%0d_in_ready", i), u_if.in_ready, 1);
            tick();
            drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00);
            chk($sformatf("v%0d_wb_valid", i), u_if.wb_valid, vecs[i].exp_v);
            if (vecs[i].exp_v) begin
                chk($sformatf("v%0d_wb_reg", i),  u_if.wb_reg, vecs[i].exp_reg);
                chk($sformatf("v%0d_wb_data", i), u_if.wb_data, vecs[i].exp_data);
            end
            chk($sformatf("v%0d_ovf_count", i), ovf_count, vecs[i].exp_cnt);
            tick();
            chk($sformatf("v%0d_drained", i), u_if.wb_valid, 0);
        end

        // Backpressure: two accepted, third stalled, then ordered drain
        u_if.wb_ready = 1'b0;
        drive(1'b1, 5'd1, 32'h0000_00A1, 1'b0, 5'd0, 2'b00);
        chk("bp_a_ready", u_if.in_ready, 1);
        tick();
        chk("bp_a_valid", u_if.wb_valid, 1);
        chk("bp_a_reg", u_if.wb_reg, 1);
        drive(1'b1, 5'd2, 32'h0000_00B2, 1'b0, 5'd0, 2'b00);
        chk("bp_b_ready", u_if.in_ready, 1);
        tick();
        drive(1'b1, 5'd3, 32'h0000_00C3, 1'b0, 5'd0, 2'b00);
        chk("bp_full_ready", u_if.in_ready, 0);
        tick();
        chk("bp_stall_ready", u_if.in_ready, 0);
        chk("bp_stall_reg", u_if.wb_reg, 1);
        chk("bp_stall_data", u_if.wb_data, 32'hA1);
        u_if.wb_ready = 1'b1;
        tick();
        chk("bp_b_reg", u_if.wb_reg, 2);
        chk("bp_b_data", u_if.wb_data, 32'hB2);
        chk("bp_b_in_ready", u_if.in_ready, 1);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00);
        chk("bp_c_valid", u_if.wb_valid, 1);
        chk("bp_c_reg", u_if.wb_reg, 3);
        chk("bp_c_data", u_if.wb_data, 32'hC3);
        tick();
        chk("bp_empty", u_if.wb_valid, 0);

        // Mid-transfer reset with two entries queued
        u_if.wb_ready = 1'b0;
        drive(1'b1, 5'd7, 32'h0000_0ABC, 1'b1, 5'd1, 2'b00);
        tick();
        drive(1'b1, 5'd2, 32'h0000_0DEF, 1'b0, 5'd0, 2'b00);
        tick();
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00);
        chk("mr_pre_valid", u_if.wb_valid, 1);
        chk("mr_pre_reg", u_if.wb_reg, TRAP_ON ? 5'd30 : 5'd7);
        chk("mr_pre_full", u_if.in_ready, 0);
        ctrl_reset_n = 1'b0;
        #1;
        chk("mr_wb_valid", u_if.wb_valid, 0);
        chk("mr_wb_reg", u_if.wb_reg, 0);
        chk("mr_wb_data", u_if.wb_data, 0);
        chk("mr_ovf_count", ovf_count, 0);
        chk("mr_in_ready", u_if.in_ready, 0);
        tick();
        ctrl_reset_n = 1'b1;
        #1;
        chk("mr_rel_in_ready", u_if.in_ready, 1);
        chk("mr_rel_wb_valid", u_if.wb_valid, 0);

        // Saturation: four trapped pushes back to back on a 2-bit counter
        u_if.wb_ready = 1'b1;
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 5'd7, 32'h0000_0123, 1'b1, 5'd0, 2'b01);
            tick();
            chk($sformatf("sat%0d_count", k), ovf_count, sat_exp[k]);
            chk($sformatf("sat%0d_reg", k), u_if.wb_reg, TRAP_ON ? 5'd30 : 5'd7);
            chk($sformatf("sat%0d_data", k), u_if.wb_data, TRAP_ON ? 32'd2 : 32'h123);
        end
        drive(1'b0, 5'd0, 32'd0, 1'b0, 5'd0, 2'b00);
        tick();
        chk("sat_drained", u_if.wb_valid, 0);
        chk("sat_hold", ovf_count, sat_exp[3]);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
